// File: rtl/bypass_rx_route_sequencer_pkg.sv
// Shared types and route encoding for the bypass RX route sequencer.
package bypass_rx_route_sequencer_pkg;

    localparam int unsigned N_REGIONS          = 4;
    localparam int unsigned CMD_LEN_BITS       = 28;
    localparam int unsigned ROUTE_BITS         = 14;
    localparam int unsigned PORT_BYPASS_RX_OFS = 6;
    localparam int unsigned PORT_BYPASS_RX     = N_REGIONS + PORT_BYPASS_RX_OFS;

    // Route field positions inside tdest
    localparam int unsigned SENDER_LSB   = 6;
    localparam int unsigned RECEIVER_LSB = 2;
    localparam int unsigned FLAGS_LSB    = 0;

    typedef struct packed {
        logic [3:0]              vfid;
        logic [CMD_LEN_BITS-1:0] len;
    } bypass_route_cmd_t;

    typedef enum logic [0:0] {StIdle, StStream} seq_state_e;

    function automatic logic [ROUTE_BITS-1:0] encode_route(input logic [3:0] sender,
                                                           input logic [3:0] receiver,
                                                           input logic [1:0] flags);
        logic [ROUTE_BITS-1:0] r;
        r = '0;
        r[SENDER_LSB +: 4]   = sender;
        r[RECEIVER_LSB +: 4] = receiver;
        r[FLAGS_LSB +: 2]    = flags;
        return r;
    endfunction

endpackage

// File: rtl/bypass_rx_route_sequencer_cmd_fifo.sv
// Command FIFO: registered ready/empty, first-word-fall-through head.
module bypass_route_cmd_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                ready_q, empty_q;
    logic                do_push, do_pop;

    assign do_push    = push_valid & ready_q;
    assign do_pop     = pop & ~empty_q;
    assign push_ready = ready_q;
    assign empty      = empty_q;
    assign head       = mem_q[rd_ptr_q];

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
    end

    // Pointers, occupancy and the registered ready/empty flags
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != CNT_BITS'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/bypass_rx_route_sequencer.sv
// Attaches a per-segment tdest route to bypass RX data, one queued WR command at a time.
module bypass_rx_route_sequencer
    import bypass_rx_route_sequencer_pkg::*;
#(
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned LEN_BITS  = CMD_LEN_BITS,
    parameter int unsigned CMD_DEPTH = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_cmd_valid,
    output logic                   s_cmd_ready,
    input  logic [3:0]             s_cmd_vfid,
    input  logic [LEN_BITS-1:0]    s_cmd_len,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [13:0]            m_axis_tdest,
    output logic                   err_short,
    output logic                   err_long,
    output logic [31:0]            seg_count
);

    localparam int unsigned BYTES      = DATA_BITS / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(BYTES);
    localparam int unsigned CMD_W      = $bits(bypass_route_cmd_t);

    seq_state_e          state_q, state_d;
    logic [13:0]         route_q, route_d;
    logic [LEN_BITS-1:0] beats_rem_q, beats_rem_d;
    logic [31:0]         seg_count_q, seg_count_d;
    logic [LEN_BITS-1:0] head_beats;
    bypass_route_cmd_t   push_cmd, head_cmd;
    logic [CMD_W-1:0]    head_raw;
    logic                fifo_empty, fifo_pop;
    logic                beat_hs, final_beat;

    assign push_cmd.vfid = s_cmd_vfid;
    assign push_cmd.len  = s_cmd_len;
    assign head_cmd      = bypass_route_cmd_t'(head_raw);

    // ceil(len / BYTES); wraps only for lengths within BYTES of the field maximum
    assign head_beats = (head_cmd.len + LEN_BITS'(BYTES - 1)) >> BYTE_SHIFT;

    bypass_route_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .aclk       (aclk),
        .areset     (areset),
        .push_valid (s_cmd_valid),
        .push_ready (s_cmd_ready),
        .push_data  (push_cmd),
        .pop        (fifo_pop),
        .empty      (fifo_empty),
        .head       (head_raw)
    );

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tdest = route_q;
    assign seg_count    = seg_count_q;

    // Next-state, handshake gating and per-beat error detection
    always_comb begin
        state_d       = state_q;
        route_d       = route_q;
        beats_rem_d   = beats_rem_q;
        seg_count_d   = seg_count_q;
        fifo_pop      = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        err_short     = 1'b0;
        err_long      = 1'b0;
        beat_hs       = 1'b0;
        final_beat    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Zero-length commands are consumed without opening the data path
                    if (head_beats != '0) begin
                        route_d     = encode_route(4'(PORT_BYPASS_RX), head_cmd.vfid, 2'b00);
                        beats_rem_d = head_beats;
                        state_d     = StStream;
                    end
                end
            end
            StStream: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                beat_hs       = s_axis_tvalid & m_axis_tready;
                final_beat    = (beats_rem_q == LEN_BITS'(1)) | s_axis_tlast;
                m_axis_tlast  = final_beat;
                if (beat_hs) begin
                    err_short = s_axis_tlast & (beats_rem_q > LEN_BITS'(1));
                    err_long  = (beats_rem_q == LEN_BITS'(1)) & ~s_axis_tlast;
                    if (final_beat) begin
                        beats_rem_d = '0;
                        seg_count_d = seg_count_q + 32'd1;
                        state_d     = StIdle;
                    end else begin
                        beats_rem_d = beats_rem_q - LEN_BITS'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, route, beat counter and segment statistics
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= StIdle;
            route_q     <= '0;
            beats_rem_q <= '0;
            seg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            beats_rem_q <= beats_rem_d;
            seg_count_q <= seg_count_d;
        end
    end

endmodule

// File: tb/tb_bypass_rx_route_sequencer.sv
// Directed, table-driven bench for bypass_rx_route_sequencer (N_REGIONS = 4, sender port 10).
module tb_bypass_rx_route_sequencer;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_cmd_valid, s_cmd_ready;
    logic [3:0]    s_cmd_vfid;
    logic [27:0]   s_cmd_len;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [13:0]   m_axis_tdest;
    logic          err_short, err_long;
    logic [31:0]   seg_count;

    int n_cmp   = 0;
    int n_fail  = 0;
    int seg_tag = 0;
    int exp_seg = 0;

    typedef struct {
        logic [3:0]  vf;
        logic [27:0] len;
        int          up_tlast;
        int          beats;
        int          e_short;
        int          e_long;
        logic [13:0] td;
        bit          bp;
    } vec_t;

    vec_t vecs[10];

    bypass_rx_route_sequencer dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .s_cmd_vfid    (s_cmd_vfid),
        .s_cmd_len     (s_cmd_len),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .err_short     (err_short),
        .err_long      (err_long),
        .seg_count     (seg_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int tag, input int b);
        return {16{32'(tag * 256 + b)}};
    endfunction

    function automatic logic [KW-1:0] beat_keep(input int tag, input int b);
        return {2{32'(tag * 7 + b + 1)}};
    endfunction

    // {4'b0, sender 10, vfid, 2'b00}
    function automatic logic [13:0] exp_route(input logic [3:0] vf);
        return {4'b0000, 4'd10, vf, 2'b00};
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the command.
    task automatic push_cmd(input logic [3:0] vf, input logic [27:0] ln);
        int guard;
        guard       = 0;
        s_cmd_valid = 1'b1;
        s_cmd_vfid  = vf;
        s_cmd_len   = ln;
        #1;
        while (!s_cmd_ready && guard < 100) begin
            @(posedge aclk); #1;
            guard++;
        end
        n_cmp++;
        if (!s_cmd_ready) begin
            n_fail++;
            $display("FAIL push_cmd: s_cmd_ready stuck at 0, want 1");
        end
        @(posedge aclk); #1;
        s_cmd_valid = 1'b0;
    endtask

    // Streams one segment and checks every output beat; stop_after > 0 abandons it mid-way.
    task automatic stream(input logic [13:0] td, input int up_tlast, input int exp_beats,
                          input int e_short, input int e_long, input bit bp,
                          input int stop_after);
        int            b, cyc, ns, nl;
        bit            done, stalled;
        logic [13:0]   h_td;
        logic [DW-1:0] h_d;
        logic          h_l;
        seg_tag++;
        b = 0; cyc = 0; ns = 0; nl = 0; done = 0; stalled = 0;
        h_td = '0; h_d = '0; h_l = 1'b0;
        s_axis_tvalid = 1'b1;
        while (!done && cyc < 400) begin
            s_axis_tdata  = beat_data(seg_tag, b);
            s_axis_tkeep  = beat_keep(seg_tag, b);
            s_axis_tlast  = (b + 1 == up_tlast);
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                chk("stall_tdest", m_axis_tdest, h_td);
                chk("stall_tdata", {63'b0, m_axis_tdata == h_d}, 64'd1);
                chk("stall_tlast", m_axis_tlast, h_l);
            end
            ns += int'(err_short);
            nl += int'(err_long);
            if (m_axis_tvalid) chk("tready_follow", s_axis_tready, m_axis_tready);
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_tdest", m_axis_tdest, td);
                chk("beat_tdata", {63'b0, m_axis_tdata == beat_data(seg_tag, b)}, 64'd1);
                chk("beat_tkeep", m_axis_tkeep, beat_keep(seg_tag, b));
                chk("beat_tlast", m_axis_tlast, (b + 1 == exp_beats));
                stalled = 0;
                b++;
                if (b == exp_beats || (stop_after != 0 && b == stop_after)) done = 1;
            end else if (m_axis_tvalid) begin
                stalled = 1;
                h_td = m_axis_tdest; h_d = m_axis_tdata; h_l = m_axis_tlast;
            end else begin
                stalled = 0;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        chk("seg_done", {63'b0, done}, 64'd1);
        chk("err_short_count", ns, e_short);
        chk("err_long_count", nl, e_long);
    endtask

    initial begin
        int hs_cyc[5];
        int nh, cyc;

        areset = 1'b1; s_cmd_valid = 1'b0; s_cmd_vfid = '0; s_cmd_len = '0;
        s_axis_tvalid = 1'b1; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;

        //                vf     len      upT beats sh lo td       bp
        vecs[0] = '{4'd2,  28'd128, 2, 2, 0, 0, 14'd648, 1'b0};
        vecs[1] = '{4'd1,  28'd64,  1, 1, 0, 0, 14'd644, 1'b0};
        vecs[2] = '{4'd3,  28'd200, 4, 4, 0, 0, 14'd652, 1'b1};
        vecs[3] = '{4'd5,  28'd65,  2, 2, 0, 0, 14'd660, 1'b0};
        vecs[4] = '{4'd7,  28'd0,   0, 0, 0, 0, 14'd0,   1'b0};
        vecs[5] = '{4'd0,  28'd64,  1, 1, 0, 0, 14'd640, 1'b0};
        vecs[6] = '{4'd4,  28'd256, 2, 2, 1, 0, 14'd656, 1'b0};
        vecs[7] = '{4'd8,  28'd64,  0, 1, 0, 1, 14'd672, 1'b0};
        vecs[8] = '{4'd15, 28'd1,   1, 1, 0, 0, 14'd700, 1'b0};
        vecs[9] = '{4'd9,  28'd192, 3, 3, 0, 0, 14'd676, 1'b1};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_cmd_ready", s_cmd_ready, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_tdest", m_axis_tdest, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_err_long", err_long, 0);
        chk("rst_seg_count", seg_count, 0);
        areset = 1'b0; s_axis_tvalid = 1'b0;
        #1;
        chk("rst_release_ready_same_cycle", s_cmd_ready, 0);
        @(posedge aclk); #1;
        chk("rst_release_ready_next", s_cmd_ready, 1);

        // Command-to-data latency: first beat accepted two cycles after the push
        seg_tag++;
        s_axis_tvalid = 1'b1; s_axis_tdata = beat_data(seg_tag, 0);
        s_axis_tkeep = beat_keep(seg_tag, 0); s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        s_cmd_valid = 1'b1; s_cmd_vfid = 4'd2; s_cmd_len = 28'd128;
        #1;
        chk("lat_t_cmd_ready", s_cmd_ready, 1);
        chk("lat_t_s_tready", s_axis_tready, 0);
        @(posedge aclk); #1;
        s_cmd_valid = 1'b0;
        #1;
        chk("lat_t1_s_tready", s_axis_tready, 0);
        chk("lat_t1_m_tvalid", m_axis_tvalid, 0);
        @(posedge aclk); #2;
        chk("lat_t2_s_tready", s_axis_tready, 1);
        chk("lat_t2_m_tvalid", m_axis_tvalid, 1);
        chk("lat_t2_tdest", m_axis_tdest, 14'd648);
        chk("lat_t2_tlast", m_axis_tlast, 0);
        chk("lat_t2_tdata", {63'b0, m_axis_tdata == beat_data(seg_tag, 0)}, 64'd1);
        @(posedge aclk); #1;
        s_axis_tdata = beat_data(seg_tag, 1); s_axis_tkeep = beat_keep(seg_tag, 1);
        s_axis_tlast = 1'b1;
        #1;
        chk("lat_b2_tdest", m_axis_tdest, 14'd648);
        chk("lat_b2_tlast", m_axis_tlast, 1);
        chk("lat_b2_err_short", err_short, 0);
        chk("lat_b2_err_long", err_long, 0);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        #1;
        exp_seg = 1;
        chk("lat_seg_count", seg_count, exp_seg);
        chk("lat_idle_s_tready", s_axis_tready, 0);

        // Back-to-back segments: route switches at the boundary after one bubble
        seg_tag++;
        push_cmd(4'd1, 28'd64);
        push_cmd(4'd3, 28'd200);
        nh = 0; cyc = 0;
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        while (nh < 5 && cyc < 50) begin
            s_axis_tdata = beat_data(seg_tag, nh);
            s_axis_tkeep = beat_keep(seg_tag, nh);
            s_axis_tlast = (nh == 0 || nh == 4);
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                chk("b2b_tdest", m_axis_tdest, (nh == 0) ? 14'd644 : 14'd652);
                chk("b2b_tlast", m_axis_tlast, (nh == 0 || nh == 4));
                hs_cyc[nh] = cyc;
                nh++;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        chk("b2b_beats", nh, 5);
        if (nh == 5) begin
            chk("b2b_bubble", hs_cyc[1] - hs_cyc[0], 2);
            chk("b2b_full_rate", hs_cyc[4] - hs_cyc[1], 3);
        end
        exp_seg += 2;
        #1;
        chk("b2b_seg_count", seg_count, exp_seg);

        // Table of single-segment vectors
        for (int i = 0; i < 10; i++) begin
            push_cmd(vecs[i].vf, vecs[i].len);
            if (vecs[i].beats == 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = beat_data(999, i);
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk("discard_s_tready", s_axis_tready, 0);
                    @(posedge aclk); #1;
                end
                s_axis_tvalid = 1'b0;
            end else begin
                stream(vecs[i].td, vecs[i].up_tlast, vecs[i].beats, vecs[i].e_short,
                       vecs[i].e_long, vecs[i].bp, 0);
                exp_seg++;
            end
            #1;
            chk("vec_seg_count", seg_count, exp_seg);
        end

        // FIFO full: a stalled blocker segment holds the FSM while 16 commands queue up
        push_cmd(4'd0, 28'd64);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("full_ready_before_push", s_cmd_ready, 1);
            push_cmd(4'(i), 28'd64);
        end
        #1;
        chk("full_ready_low", s_cmd_ready, 0);
        stream(exp_route(4'd0), 1, 1, 0, 0, 1'b0, 0);
        exp_seg++;
        #1;
        chk("full_ready_pop_cycle", s_cmd_ready, 0);
        @(posedge aclk); #1;
        chk("full_ready_after_pop", s_cmd_ready, 1);
        for (int i = 0; i < 16; i++) begin
            stream(exp_route(4'(i)), 1, 1, 0, 0, 1'b0, 0);
            exp_seg++;
        end
        #1;
        chk("full_seg_count", seg_count, exp_seg);

        // Backpressure then reset mid-segment with one more command still queued
        push_cmd(4'd6, 28'd640);
        push_cmd(4'd9, 28'd64);
        stream(exp_route(4'd6), 0, 10, 0, 0, 1'b1, 4);
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1; areset = 1'b1;
        @(posedge aclk); #1;
        chk("mrst_cmd_ready", s_cmd_ready, 0);
        chk("mrst_s_tready", s_axis_tready, 0);
        chk("mrst_m_tvalid", m_axis_tvalid, 0);
        chk("mrst_m_tlast", m_axis_tlast, 0);
        chk("mrst_tdest", m_axis_tdest, 0);
        chk("mrst_err_short", err_short, 0);
        chk("mrst_err_long", err_long, 0);
        chk("mrst_seg_count", seg_count, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        chk("mrst_ready_same_cycle", s_cmd_ready, 0);
        @(posedge aclk); #1;
        chk("mrst_ready_next", s_cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mrst_fifo_empty_s_tready", s_axis_tready, 0);
            chk("mrst_fifo_empty_m_tvalid", m_axis_tvalid, 0);
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        push_cmd(4'd2, 28'd64);
        stream(14'd648, 1, 1, 0, 0, 1'b0, 0);
        #1;
        chk("post_rst_seg_count", seg_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
